// File: rtl/sng_dsc_stream_if.sv
// sng_dsc_stream_if: command and bitstream bundle between operand registers, generator and SC array
interface sng_dsc_stream_if #(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1,
    parameter int NUM_CH = 1
);
    logic                       start;
    logic [1:0]                 mode;
    logic [WIDTH-1:0]           seed;
    logic [NUM_CH*WIDTH-1:0]    bin_in;
    logic                       busy;
    logic [NUM_CH*STRIDE-1:0]   sn_out;
    logic                       sn_valid;
    logic                       sn_ready;
    logic                       sn_last;
    logic                       done;

    modport master (
        input  start, mode, seed, bin_in, sn_ready,
        output busy, sn_out, sn_valid, sn_last, done
    );

    modport slave (
        output start, mode, seed, bin_in, sn_ready,
        input  busy, sn_out, sn_valid, sn_last, done
    );
endinterface

// File: rtl/sng_dsc_stream.sv
// sng_dsc_stream: multi-channel stochastic number generator with a shared unary or extended-LFSR reference
module sng_dsc_stream #(
    parameter int WIDTH  = 4,
    parameter int STRIDE = 1,
    parameter int NUM_CH = 1
) (
    input  logic clk,
    input  logic rst,
    sng_dsc_stream_if.master bus
);
    // Fibonacci tap masks (bit t-1 set for tap t) of primitive polynomials, widths 4..12
    localparam logic [11:0] TAP_TABLE =
        WIDTH == 4  ? 12'h00C : WIDTH == 5  ? 12'h014 : WIDTH == 6  ? 12'h030 :
        WIDTH == 7  ? 12'h060 : WIDTH == 8  ? 12'h0B8 : WIDTH == 9  ? 12'h110 :
        WIDTH == 10 ? 12'h240 : WIDTH == 11 ? 12'h500 : 12'h829;
    localparam logic [WIDTH-1:0] TAPS     = TAP_TABLE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(STRIDE);
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'((1 << WIDTH) - STRIDE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state;
    logic [NUM_CH*WIDTH-1:0]    bin_lat;
    logic [1:0]                 mode_lat;
    logic [WIDTH-1:0]           lfsr;
    logic [WIDTH-1:0]           lfsr_nxt;
    logic [WIDTH-1:0]           idx;
    logic                       busy_q;
    logic                       valid_q;
    logic                       done_q;
    logic                       last;
    logic [NUM_CH*STRIDE-1:0]   bits;

    // The NOR term splices the all-zero state in after 100..0, giving a full 2^WIDTH cycle
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], (^(s & TAPS)) ^ ~|s[WIDTH-2:0]};
    endfunction

    // Per lane: chained LFSR successor, reference select, and one comparator per channel
    for (genvar j = 0; j < STRIDE; j++) begin : g_lane
        logic [WIDTH-1:0] st;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] r;
        if (j == 0) begin : g_first
            assign st = lfsr;
        end else begin : g_next
            assign st = lfsr_step(g_lane[j-1].st);
        end
        assign cnt = idx + WIDTH'(j);
        assign r   = mode_lat == 2'd1 ? ~cnt : mode_lat == 2'd2 ? st : cnt;
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign bits[i*STRIDE+j] = bin_lat[i*WIDTH +: WIDTH] > r;
        end
    end

    assign lfsr_nxt     = lfsr_step(g_lane[STRIDE-1].st);
    assign last         = idx == LAST_IDX;
    assign bus.busy     = busy_q;
    assign bus.sn_valid = valid_q;
    assign bus.done     = done_q;
    assign bus.sn_last  = valid_q & last;
    assign bus.sn_out   = valid_q ? bits : '0;

    // Command FSM: latch operands on start, step idx/LFSR per handshake, pulse done after the last beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bin_lat  <= '0;
            mode_lat <= '0;
            lfsr     <= '0;
            idx      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    state    <= RUN;
                    busy_q   <= 1'b1;
                    valid_q  <= 1'b1;
                    bin_lat  <= bus.bin_in;
                    mode_lat <= bus.mode;
                    lfsr     <= bus.seed;
                    idx      <= '0;
                end
            end else if (valid_q && bus.sn_ready) begin
                if (last) begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    idx  <= idx + STEP;
                    lfsr <= lfsr_nxt;
                end
            end
        end
    end
endmodule
